sysid_boot_checker: RTL and testbench
=====================================

// Module: sysid_boot_checker
// PURPOSE
// Owns the 1-bit-address, 32-bit-readdata system ID slave and shares it between the CPU
// and a built-in boot check. The check reads the ID word (address 0) and the timestamp
// word (address 1), then compares both against build-time expected values.
// A CPU read that arrives while the check is running is stalled with waitrequest.
// The result flags gate software bring-up and drive a board "image OK" LED.
// PARAMETERS
// EXPECTED_ID  32'd0           value required at slave address 0
// EXPECTED_TS  32'd1665655599  value required at slave address 1
// READ_LAT     0               extra cycles slave address is held before readdata is sampled (0..15)
// AUTO_START   1               1: a check runs automatically after reset release
// PORTS
// clock            in   1   single clock domain
// reset            in   1   asynchronous, active-high
// start            in   1   single-cycle request to (re)run the check
// cpu_address      in   1   CPU read address (0 = ID, 1 = timestamp)
// cpu_read         in   1   CPU read strobe; held with cpu_address while waitrequest=1
// cpu_readdata     out  32  id_readdata passed through in the CPU accept cycle, else 0
// cpu_waitrequest  out  1   1 = CPU read stalled
// id_address       out  1   address driven to the system ID slave
// id_readdata      in   32  slave read data (combinational from id_address)
// busy             out  1   check in progress
// done             out  1   sticky: a check has completed since last start/reset
// id_ok, ts_ok     out  1   compare results, valid when done=1
// pass             out  1   done & id_ok & ts_ok
// id_value         out  32  captured ID word
// ts_value         out  32  captured timestamp word
// BEHAVIOUR
// - Reset (async): state=IDLE, cnt=0, all outputs 0 (id_address=0).
//   pending=AUTO_START, done=0.
// - FSM states: IDLE, RD_ID, RD_TS, CPU_RD. cnt is max(1,$clog2(READ_LAT+1)) bits and is
//   cleared on every state entry.
// - IDLE: pending|start -> RD_ID, clear pending, done, id_ok, ts_ok.
//   Otherwise, cpu_read -> CPU_RD. The check has priority when both are true.
// - RD_ID: id_address=0. When cnt<READ_LAT, cnt++. When cnt==READ_LAT, capture id_value
//   and id_ok=(id_readdata==EXPECTED_ID), then -> RD_TS.
// - RD_TS: id_address=1. Same count. When cnt==READ_LAT, capture ts_value and
//   ts_ok=(id_readdata==EXPECTED_TS), set done=1 in the same edge, then -> IDLE.
// - CPU_RD: id_address=cpu_address. When cnt==READ_LAT, cpu_waitrequest=0 and
//   cpu_readdata=id_readdata (combinational) -> IDLE. Exactly one accept cycle per read.
// - cpu_waitrequest=1 in every cycle except the CPU_RD accept cycle, including while
//   idle with cpu_read high.
// - CPU read latency: the read is accepted READ_LAT+1 cycles after cpu_read is first
//   seen in IDLE.
// - Check latency with READ_LAT=0: done rises on the 3rd edge after start is sampled.
//   In general it is 1+2*(READ_LAT+1) edges.
// - busy = (state==RD_ID | state==RD_TS).
// - start while busy or in CPU_RD: ignored, not queued.
// - cpu_read during a check: stalled, then serviced after return to IDLE.
// - done, id_ok, ts_ok, id_value and ts_value hold until the next check starts or until reset.
// - Reset mid-check: everything clears at once. With AUTO_START=1 the check restarts
//   from RD_ID after reset release. No partial done is ever reported.
// TESTING
// - AUTO_START=1, READ_LAT=0, slave returns 0 / 1665655599: release reset -> done=1 on
//   the 3rd edge, id_value=0, ts_value=1665655599, id_ok=ts_ok=pass=1.
// - Slave timestamp 32'h12345678, start pulse -> done=1, id_ok=1, ts_ok=0, pass=0,
//   ts_value=32'h12345678.
// - READ_LAT=2, idle, cpu_read with cpu_address=1 -> waitrequest=1 for 3 cycles, then 0 for
//   1 cycle with cpu_readdata=1665655599; id_address=1 throughout.
// - start and cpu_read in the same cycle -> check runs first with waitrequest=1
//   throughout. The CPU read is accepted READ_LAT+1 cycles after busy falls.
// - reset asserted during RD_TS -> all outputs 0 asynchronously. AUTO_START=0: no done
//   until the next start.
// - Second start pulse while busy -> exactly one done rising edge; captured values match
//   the first run.

Source files
------------

// File: rtl/sysid_boot_checker.sv
// Shares the system ID slave between the CPU and a built-in boot check.
// The check reads the ID and timestamp words and compares them with build-time values.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1665655599,
  parameter int          READ_LAT    = 0,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        cpu_address,
  input  logic        cpu_read,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic        id_address,
  input  logic [31:0] id_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int CW = ($clog2(READ_LAT + 1) > 1) ? $clog2(READ_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(READ_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    CPU_RD = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          pending_r, pending_s;
  logic          done_r, done_s;
  logic          id_ok_r, id_ok_s;
  logic          ts_ok_r, ts_ok_s;
  logic          pass_r, pass_s;
  logic [31:0]   id_value_r, id_value_s;
  logic [31:0]   ts_value_r, ts_value_s;
  logic          id_address_s;
  logic          accept_s;
  logic          cnt_hit_s;

  assign cnt_hit_s = (cnt_r == CNT_MAX);

  // State and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      pending_r  <= AUTO_START;
      done_r     <= 1'b0;
      id_ok_r    <= 1'b0;
      ts_ok_r    <= 1'b0;
      pass_r     <= 1'b0;
      id_value_r <= 32'd0;
      ts_value_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pending_r  <= pending_s;
      done_r     <= done_s;
      id_ok_r    <= id_ok_s;
      ts_ok_r    <= ts_ok_s;
      pass_r     <= pass_s;
      id_value_r <= id_value_s;
      ts_value_r <= ts_value_s;
    end
  end

  // Next-state, capture and slave-address decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    pending_s    = pending_r;
    done_s       = done_r;
    id_ok_s      = id_ok_r;
    ts_ok_s      = ts_ok_r;
    id_value_s   = id_value_r;
    ts_value_s   = ts_value_r;
    id_address_s = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        id_address_s = cpu_read ? cpu_address : 1'b0;
        // The boot check wins over a simultaneous CPU read.
        if (pending_r || start) begin
          state_s   = RD_ID;
          cnt_s     = '0;
          pending_s = 1'b0;
          done_s    = 1'b0;
          id_ok_s   = 1'b0;
          ts_ok_s   = 1'b0;
        end else if (cpu_read) begin
          state_s = CPU_RD;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      RD_ID: begin
        id_address_s = 1'b0;
        if (cnt_hit_s) begin
          id_value_s = id_readdata;
          id_ok_s    = (id_readdata == EXPECTED_ID);
          state_s    = RD_TS;
          cnt_s      = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RD_TS: begin
        id_address_s = 1'b1;
        if (cnt_hit_s) begin
          ts_value_s = id_readdata;
          ts_ok_s    = (id_readdata == EXPECTED_TS);
          done_s     = 1'b1;
          state_s    = IDLE;
          cnt_s      = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      CPU_RD: begin
        id_address_s = cpu_address;
        if (cnt_hit_s) begin
          accept_s = 1'b1;
          state_s  = IDLE;
          cnt_s    = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
    pass_s = done_s & id_ok_s & ts_ok_s;
  end

  // Reset forces the combinational bus outputs low along with the registers.
  assign id_address      = reset ? 1'b0 : id_address_s;
  assign cpu_waitrequest = reset ? 1'b0 : ~accept_s;
  assign cpu_readdata    = (accept_s && !reset) ? id_readdata : 32'd0;

  assign busy     = (state_r == RD_ID) || (state_r == RD_TS);
  assign done     = done_r;
  assign id_ok    = id_ok_r;
  assign ts_ok    = ts_ok_r;
  assign pass     = pass_r;
  assign id_value = id_value_r;
  assign ts_value = ts_value_r;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: three instances (auto/lat0, auto/lat2, manual/lat0) share one
// behavioural ID slave whose two words the bench sets.
module tb_sysid_boot_checker;

  localparam logic [31:0] TS_GOOD = 32'd1665655599;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  start, cpu_address, cpu_read;
  logic [2:0]  cpu_waitrequest, id_address, busy, done, id_ok, ts_ok, pass;
  logic [31:0] cpu_readdata [3];
  logic [31:0] id_readdata  [3];
  logic [31:0] id_value     [3];
  logic [31:0] ts_value     [3];
  logic [31:0] id_word, ts_word;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign id_readdata[g] = id_address[g] ? ts_word : id_word;
    sysid_boot_checker #(
      .EXPECTED_ID(32'd0),
      .EXPECTED_TS(TS_GOOD),
      .READ_LAT((g == 1) ? 2 : 0),
      .AUTO_START((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .start(start[g]),
      .cpu_address(cpu_address[g]),
      .cpu_read(cpu_read[g]),
      .cpu_readdata(cpu_readdata[g]),
      .cpu_waitrequest(cpu_waitrequest[g]),
      .id_address(id_address[g]),
      .id_readdata(id_readdata[g]),
      .busy(busy[g]),
      .done(done[g]),
      .id_ok(id_ok[g]),
      .ts_ok(ts_ok[g]),
      .pass(pass[g]),
      .id_value(id_value[g]),
      .ts_value(ts_value[g])
    );
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 3'b000;
    cpu_address = 3'b000;
    cpu_read = 3'b000;
    id_word = 32'd0;
    ts_word = TS_GOOD;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_idaddr", 32'(id_address), 32'd0);
    chk("rst_wait", 32'(cpu_waitrequest), 32'd0);
    chk("rst_idval0", id_value[0], 32'd0);

    // Auto check after release, READ_LAT=0: done on the 3rd edge
    reset = 1'b0;
    tick();
    chk("auto_e1_busy0", 32'(busy[0]), 32'd1);
    chk("auto_e1_idaddr0", 32'(id_address[0]), 32'd0);
    tick();
    chk("auto_e2_idaddr0", 32'(id_address[0]), 32'd1);
    chk("auto_e2_done0", 32'(done[0]), 32'd0);
    tick();
    chk("auto_e3_done0", 32'(done[0]), 32'd1);
    chk("auto_e3_busy0", 32'(busy[0]), 32'd0);
    chk("auto_idok0", 32'(id_ok[0]), 32'd1);
    chk("auto_tsok0", 32'(ts_ok[0]), 32'd1);
    chk("auto_pass0", 32'(pass[0]), 32'd1);
    chk("auto_idval0", id_value[0], 32'd0);
    chk("auto_tsval0", ts_value[0], TS_GOOD);
    chk("auto_manual_idle2", 32'(done[2] | busy[2]), 32'd0);

    // READ_LAT=2 instance: done on edge 7, not 6
    tick(); tick(); tick();
    chk("lat2_e6_done1", 32'(done[1]), 32'd0);
    tick();
    chk("lat2_e7_done1", 32'(done[1]), 32'd1);
    chk("lat2_pass1", 32'(pass[1]), 32'd1);

    // Bad timestamp on a manual start
    ts_word = 32'h12345678;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("bad_done_cleared", 32'(done[0]), 32'd0);
    chk("bad_busy", 32'(busy[0]), 32'd1);
    tick(); tick();
    chk("bad_done", 32'(done[0]), 32'd1);
    chk("bad_idok", 32'(id_ok[0]), 32'd1);
    chk("bad_tsok", 32'(ts_ok[0]), 32'd0);
    chk("bad_pass", 32'(pass[0]), 32'd0);
    chk("bad_tsval", ts_value[0], 32'h12345678);
    ts_word = TS_GOOD;

    // CPU read with READ_LAT=2 at address 1
    cpu_read[1] = 1'b1;
    cpu_address[1] = 1'b1;
    #1;
    chk("cpu_c0_wait", 32'(cpu_waitrequest[1]), 32'd1);
    chk("cpu_c0_idaddr", 32'(id_address[1]), 32'd1);
    tick();
    chk("cpu_c1_wait", 32'(cpu_waitrequest[1]), 32'd1);
    chk("cpu_c1_idaddr", 32'(id_address[1]), 32'd1);
    tick();
    chk("cpu_c2_wait", 32'(cpu_waitrequest[1]), 32'd1);
    tick();
    chk("cpu_acc_wait", 32'(cpu_waitrequest[1]), 32'd0);
    chk("cpu_acc_data", cpu_readdata[1], TS_GOOD);
    chk("cpu_acc_idaddr", 32'(id_address[1]), 32'd1);
    cpu_read[1] = 1'b0;
    tick();
    chk("cpu_after_wait", 32'(cpu_waitrequest[1]), 32'd1);
    chk("cpu_after_data", cpu_readdata[1], 32'd0);

    // start and cpu_read together: the check goes first
    start[0] = 1'b1;
    cpu_read[0] = 1'b1;
    cpu_address[0] = 1'b1;
    #1;
    chk("prio_c0_wait", 32'(cpu_waitrequest[0]), 32'd1);
    tick();
    start[0] = 1'b0;
    chk("prio_busy", 32'(busy[0]), 32'd1);
    chk("prio_e1_wait", 32'(cpu_waitrequest[0]), 32'd1);
    tick();
    chk("prio_e2_wait", 32'(cpu_waitrequest[0]), 32'd1);
    tick();
    chk("prio_e3_busy", 32'(busy[0]), 32'd0);
    chk("prio_e3_pass", 32'(pass[0]), 32'd1);
    chk("prio_e3_wait", 32'(cpu_waitrequest[0]), 32'd1);
    tick();
    chk("prio_acc_wait", 32'(cpu_waitrequest[0]), 32'd0);
    chk("prio_acc_data", cpu_readdata[0], TS_GOOD);
    cpu_read[0] = 1'b0;
    tick();
    chk("prio_after_wait", 32'(cpu_waitrequest[0]), 32'd1);

    // Second start while busy is ignored
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("dbl_busy", 32'(busy[0]), 32'd1);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("dbl_e2_done", 32'(done[0]), 32'd0);
    tick();
    chk("dbl_done", 32'(done[0]), 32'd1);
    tick();
    chk("dbl_no_rerun_busy", 32'(busy[0]), 32'd0);
    chk("dbl_no_rerun_done", 32'(done[0]), 32'd1);
    chk("dbl_idval", id_value[0], 32'd0);
    chk("dbl_tsval", ts_value[0], TS_GOOD);

    // Reset during RD_TS on the manual instance
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    tick();
    chk("mid_rdts_idaddr2", 32'(id_address[2]), 32'd1);
    chk("mid_rdts_busy2", 32'(busy[2]), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy2", 32'(busy[2]), 32'd0);
    chk("mid_rst_idaddr2", 32'(id_address[2]), 32'd0);
    chk("mid_rst_done2", 32'(done[2]), 32'd0);
    chk("mid_rst_wait2", 32'(cpu_waitrequest[2]), 32'd0);
    chk("mid_rst_tsval0", ts_value[0], 32'd0);
    chk("mid_rst_done0", 32'(done[0]), 32'd0);
    tick();
    reset = 1'b0;
    id_word = 32'hDEADBEEF;
    tick(); tick(); tick();
    chk("post_rst_done2", 32'(done[2]), 32'd0);
    chk("post_rst_busy2", 32'(busy[2]), 32'd0);
    chk("post_rst_done0", 32'(done[0]), 32'd1);
    chk("post_rst_idok0", 32'(id_ok[0]), 32'd0);
    chk("post_rst_pass0", 32'(pass[0]), 32'd0);

    // Manual check with a wrong ID word
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    tick(); tick();
    chk("man_done2", 32'(done[2]), 32'd1);
    chk("man_idok2", 32'(id_ok[2]), 32'd0);
    chk("man_tsok2", 32'(ts_ok[2]), 32'd1);
    chk("man_pass2", 32'(pass[2]), 32'd0);
    chk("man_idval2", id_value[2], 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
